// File: rtl/xr_host_port.sv
// Host-side initiator for the XR bus: turns host register strobes into single
// xr_sel/xr_ack transactions and keeps one read-ahead word for the host.
module xr_host_port #(
    parameter bit PREFETCH = 1'b1
) (
    input  logic        clk,
    input  logic        reset_i,
    input  logic        addr_wr_i,
    input  logic [15:0] addr_i,
    input  logic        data_wr_i,
    input  logic [15:0] data_i,
    input  logic        data_rd_i,
    input  logic [15:0] incr_i,
    output logic [15:0] rd_data_o,
    output logic        busy_o,
    output logic        overrun_o,
    output logic        xr_sel_o,
    input  logic        xr_ack_i,
    output logic        xr_wr_o,
    output logic [15:0] xr_addr_o,
    output logic [15:0] xr_data_o,
    input  logic [15:0] xr_data_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        GAP  = 2'd2,
        RD   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] rd_data_q, rd_data_d;
    logic        busy_q, busy_d;
    logic        overrun_q, overrun_d;
    logic        xr_sel_q, xr_sel_d;
    logic        xr_wr_q, xr_wr_d;
    logic [15:0] xr_addr_q, xr_addr_d;
    logic [15:0] xr_data_q, xr_data_d;

    logic        any_strobe;
    logic        multi_strobe;
    logic [15:0] addr_next;

    assign any_strobe   = addr_wr_i | data_wr_i | data_rd_i;
    assign multi_strobe = (addr_wr_i & (data_wr_i | data_rd_i)) | (data_wr_i & data_rd_i);
    assign addr_next    = addr_q + incr_i;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rd_data_d = rd_data_q;
        overrun_d = 1'b0;
        xr_sel_d  = xr_sel_q;
        xr_wr_d   = xr_wr_q;
        xr_addr_d = xr_addr_q;
        xr_data_d = xr_data_q;

        case (state_q)
            IDLE: begin
                // Strobe priority: addr_wr > data_wr > data_rd; losers are reported.
                overrun_d = multi_strobe;
                if (addr_wr_i) begin
                    addr_d = addr_i;
                    if (PREFETCH) begin
                        state_d   = RD;
                        xr_sel_d  = 1'b1;
                        xr_wr_d   = 1'b0;
                        xr_addr_d = addr_i;
                    end
                end else if (data_wr_i) begin
                    state_d   = WR;
                    xr_sel_d  = 1'b1;
                    xr_wr_d   = 1'b1;
                    xr_addr_d = addr_q;
                    xr_data_d = data_i;
                end else if (data_rd_i) begin
                    addr_d = addr_next;
                    if (PREFETCH) begin
                        state_d   = RD;
                        xr_sel_d  = 1'b1;
                        xr_wr_d   = 1'b0;
                        xr_addr_d = addr_next;
                    end
                end
            end
            WR: begin
                overrun_d = any_strobe;
                if (xr_ack_i) begin
                    addr_d   = addr_next;
                    xr_sel_d = 1'b0;
                    state_d  = PREFETCH ? GAP : IDLE;
                end
            end
            GAP: begin
                // One dead cycle so the arbiter always sees sel low between requests.
                overrun_d = any_strobe;
                state_d   = RD;
                xr_sel_d  = 1'b1;
                xr_wr_d   = 1'b0;
                xr_addr_d = addr_q;
            end
            RD: begin
                overrun_d = any_strobe;
                if (xr_ack_i) begin
                    rd_data_d = xr_data_i;
                    xr_sel_d  = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                xr_sel_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q   <= IDLE;
            addr_q    <= 16'h0000;
            rd_data_q <= 16'h0000;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            xr_sel_q  <= 1'b0;
            xr_wr_q   <= 1'b0;
            xr_addr_q <= 16'h0000;
            xr_data_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rd_data_q <= rd_data_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
            xr_sel_q  <= xr_sel_d;
            xr_wr_q   <= xr_wr_d;
            xr_addr_q <= xr_addr_d;
            xr_data_q <= xr_data_d;
        end
    end

    assign rd_data_o = rd_data_q;
    assign busy_o    = busy_q;
    assign overrun_o = overrun_q;
    assign xr_sel_o  = xr_sel_q;
    assign xr_wr_o   = xr_wr_q;
    assign xr_addr_o = xr_addr_q;
    assign xr_data_o = xr_data_q;

endmodule

// File: tb/tb_xr_host_port.sv
// Bench for xr_host_port: host op table plus hand sequences, with an XR responder
// that scores each request against an expected queue.
module tb_xr_host_port;

    localparam logic [1:0] OP_AW = 2'd0;
    localparam logic [1:0] OP_DW = 2'd1;
    localparam logic [1:0] OP_DR = 2'd2;

    logic        clk;
    logic        reset_i;
    logic        addr_wr_i;
    logic [15:0] addr_i;
    logic        data_wr_i;
    logic [15:0] data_i;
    logic        data_rd_i;
    logic [15:0] incr_i;
    logic [15:0] rd_data_o;
    logic        busy_o;
    logic        overrun_o;
    logic        xr_sel_o;
    logic        xr_ack_i;
    logic        xr_wr_o;
    logic [15:0] xr_addr_o;
    logic [15:0] xr_data_o;
    logic [15:0] xr_data_i;

    int total = 0;
    int bad   = 0;

    logic [32:0] exp_q[$];

    logic resp_hold = 1'b0;
    logic stray_ack = 1'b0;

    xr_host_port #(.PREFETCH(1'b1)) dut (
        .clk       (clk),
        .reset_i   (reset_i),
        .addr_wr_i (addr_wr_i),
        .addr_i    (addr_i),
        .data_wr_i (data_wr_i),
        .data_i    (data_i),
        .data_rd_i (data_rd_i),
        .incr_i    (incr_i),
        .rd_data_o (rd_data_o),
        .busy_o    (busy_o),
        .overrun_o (overrun_o),
        .xr_sel_o  (xr_sel_o),
        .xr_ack_i  (xr_ack_i),
        .xr_wr_o   (xr_wr_o),
        .xr_addr_o (xr_addr_o),
        .xr_data_o (xr_data_o),
        .xr_data_i (xr_data_i)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] rd_model(input logic [15:0] a);
        return a ^ 16'h9234;
    endfunction

    function automatic logic [32:0] mk(input logic wr, input logic [15:0] a, input logic [15:0] d);
        return {wr, a, (wr ? d : 16'h0000)};
    endfunction

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // XR responder: acks after a random latency and scores each request.
    initial begin : responder
        logic        prev_sel;
        logic        last_wr;
        logic        stray;
        int          low_run;
        int          wait_cnt;
        int          lat;
        logic [32:0] e;
        prev_sel  = 1'b0;
        last_wr   = 1'b0;
        stray     = 1'b0;
        low_run   = 100;
        wait_cnt  = 0;
        lat       = 2;
        xr_ack_i  = 1'b0;
        xr_data_i = 16'h0000;
        forever begin
            @(negedge clk);
            if (!xr_sel_o) begin
                low_run++;
            end else if (!prev_sel) begin
                if (last_wr) check("gap_len", 33'(low_run), 33'(1));
                low_run = 0;
            end
            prev_sel = xr_sel_o;
            if (xr_ack_i) begin
                if (!stray) check("sel_fall", 33'(xr_sel_o), 33'(0));
                xr_ack_i  = 1'b0;
                xr_data_i = 16'h0000;
                stray     = 1'b0;
            end else if (stray_ack && !xr_sel_o) begin
                stray     = 1'b1;
                stray_ack = 1'b0;
                xr_ack_i  = 1'b1;
                xr_data_i = 16'hdead;
            end else if (xr_sel_o && !resp_hold) begin
                if (wait_cnt < lat) begin
                    wait_cnt++;
                end else begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_xr", mk(xr_wr_o, xr_addr_o, xr_data_o), 33'h1ffffffff);
                    end else begin
                        e = exp_q.pop_front();
                        check("xr_req", mk(xr_wr_o, xr_addr_o, xr_data_o), e);
                    end
                    last_wr   = xr_wr_o;
                    xr_ack_i  = 1'b1;
                    xr_data_i = xr_wr_o ? 16'h0000 : rd_model(xr_addr_o);
                    wait_cnt  = 0;
                    lat       = $urandom_range(0, 3);
                end
            end
        end
    end

    // driver tasks
    task automatic strobe(input logic aw, input logic dw, input logic dr,
                          input logic [15:0] val, input logic [15:0] incr,
                          input logic exp_ov, input logic exp_busy);
        @(negedge clk);
        addr_wr_i = aw;
        data_wr_i = dw;
        data_rd_i = dr;
        addr_i    = val;
        data_i    = val;
        incr_i    = incr;
        @(negedge clk);
        addr_wr_i = 1'b0;
        data_wr_i = 1'b0;
        data_rd_i = 1'b0;
        check("overrun", 33'(overrun_o), 33'(exp_ov));
        check("busy", 33'(busy_o), 33'(exp_busy));
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 300; n++) begin
            if (!busy_o) break;
            @(negedge clk);
        end
        check("idle_timeout", 33'(busy_o), 33'(0));
    endtask

    task automatic do_op(input logic [1:0] op, input logic [15:0] val, input logic [15:0] incr);
        strobe(op == OP_AW, op == OP_DW, op == OP_DR, val, incr, 1'b0, 1'b1);
        wait_idle();
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [15:0] val;
        logic [15:0] incr;
        int          n_exp;
        logic [32:0] e0;
        logic [32:0] e1;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t vecs[10];

    initial begin : main
        logic [15:0] m_addr;
        logic [15:0] r_incr;

        vecs[0] = '{OP_AW, 16'h8000, 16'h0001, 1, mk(0, 16'h8000, 0), 33'h0, rd_model(16'h8000)};
        vecs[1] = '{OP_AW, 16'h0010, 16'h0001, 1, mk(0, 16'h0010, 0), 33'h0, rd_model(16'h0010)};
        vecs[2] = '{OP_DW, 16'habcd, 16'h0001, 2, mk(1, 16'h0010, 16'habcd), mk(0, 16'h0011, 0), rd_model(16'h0011)};
        vecs[3] = '{OP_DR, 16'h0000, 16'h0001, 1, mk(0, 16'h0012, 0), 33'h0, rd_model(16'h0012)};
        vecs[4] = '{OP_AW, 16'hffff, 16'h0001, 1, mk(0, 16'hffff, 0), 33'h0, rd_model(16'hffff)};
        vecs[5] = '{OP_DR, 16'h0000, 16'h0001, 1, mk(0, 16'h0000, 0), 33'h0, rd_model(16'h0000)};
        vecs[6] = '{OP_DR, 16'h0000, 16'hffff, 1, mk(0, 16'hffff, 0), 33'h0, rd_model(16'hffff)};
        vecs[7] = '{OP_DW, 16'h5555, 16'h0100, 2, mk(1, 16'hffff, 16'h5555), mk(0, 16'h00ff, 0), rd_model(16'h00ff)};
        vecs[8] = '{OP_DR, 16'h0000, 16'h0002, 1, mk(0, 16'h0101, 0), 33'h0, rd_model(16'h0101)};
        vecs[9] = '{OP_DW, 16'h0001, 16'h0000, 2, mk(1, 16'h0101, 16'h0001), mk(0, 16'h0101, 0), rd_model(16'h0101)};

        reset_i   = 1'b1;
        addr_wr_i = 1'b0;
        data_wr_i = 1'b0;
        data_rd_i = 1'b0;
        addr_i    = 16'h0000;
        data_i    = 16'h0000;
        incr_i    = 16'h0001;
        repeat (3) @(negedge clk);
        reset_i = 1'b0;
        check("rst_sel", 33'(xr_sel_o), 33'(0));
        check("rst_busy", 33'(busy_o), 33'(0));
        check("rst_ovr", 33'(overrun_o), 33'(0));
        check("rst_rd", 33'(rd_data_o), 33'(0));
        check("rst_req", {xr_wr_o, xr_addr_o, xr_data_o}, 33'h0);

        // table-driven host ops
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(vecs[i].e0);
            if (vecs[i].n_exp > 1) exp_q.push_back(vecs[i].e1);
            do_op(vecs[i].op, vecs[i].val, vecs[i].incr);
            check("vec_drain", 33'(exp_q.size()), 33'(0));
            check("vec_rd", 33'(rd_data_o), 33'(vecs[i].exp_rd));
        end

        // random increments on data reads
        m_addr = 16'h0101;
        for (int i = 0; i < 6; i++) begin
            r_incr = 16'($urandom_range(0, 65535));
            m_addr = m_addr + r_incr;
            exp_q.push_back(mk(0, m_addr, 0));
            do_op(OP_DR, 16'h0000, r_incr);
            check("rnd_rd", 33'(rd_data_o), 33'(rd_model(m_addr)));
        end

        // write request held stable while ack is withheld
        exp_q.push_back(mk(0, 16'h0020, 0));
        do_op(OP_AW, 16'h0020, 16'h0001);
        resp_hold = 1'b1;
        exp_q.push_back(mk(1, 16'h0020, 16'hc3c3));
        exp_q.push_back(mk(0, 16'h0021, 0));
        strobe(1'b0, 1'b1, 1'b0, 16'hc3c3, 16'h0001, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            check("hold_req", {14'h0, xr_sel_o, xr_wr_o, xr_addr_o}, {14'h0, 1'b1, 1'b1, 16'h0020});
            check("hold_data", 33'(xr_data_o), 33'(16'hc3c3));
            @(negedge clk);
        end
        resp_hold = 1'b0;
        wait_idle();
        check("hold_rd", 33'(rd_data_o), 33'(rd_model(16'h0021)));

        // strobe while busy is dropped
        resp_hold = 1'b1;
        exp_q.push_back(mk(0, 16'h0200, 0));
        strobe(1'b1, 1'b0, 1'b0, 16'h0200, 16'h0001, 1'b0, 1'b1);
        strobe(1'b0, 1'b1, 1'b0, 16'h7777, 16'h0001, 1'b1, 1'b1);
        @(negedge clk);
        check("ovr_pulse_len", 33'(overrun_o), 33'(0));
        resp_hold = 1'b0;
        wait_idle();
        repeat (4) @(negedge clk);
        check("busy_drop_q", 33'(exp_q.size()), 33'(0));
        check("busy_drop_rd", 33'(rd_data_o), 33'(rd_model(16'h0200)));

        // addr_wr and data_rd together: addr_wr wins
        exp_q.push_back(mk(0, 16'h0300, 0));
        strobe(1'b1, 1'b0, 1'b1, 16'h0300, 16'h0001, 1'b1, 1'b1);
        wait_idle();
        repeat (4) @(negedge clk);
        check("coll_q", 33'(exp_q.size()), 33'(0));
        check("coll_rd", 33'(rd_data_o), 33'(rd_model(16'h0300)));
        exp_q.push_back(mk(0, 16'h0301, 0));
        do_op(OP_DR, 16'h0000, 16'h0001);
        check("coll_next_rd", 33'(rd_data_o), 33'(rd_model(16'h0301)));

        // reset with a read outstanding
        resp_hold = 1'b1;
        exp_q.push_back(mk(0, 16'h0400, 0));
        strobe(1'b1, 1'b0, 1'b0, 16'h0400, 16'h0001, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        check("mid_rst_sel", 33'(xr_sel_o), 33'(0));
        check("mid_rst_busy", 33'(busy_o), 33'(0));
        check("mid_rst_rd", 33'(rd_data_o), 33'(0));
        exp_q.delete();
        stray_ack = 1'b1;
        resp_hold = 1'b0;
        repeat (5) @(negedge clk);
        check("stray_done", 33'(stray_ack), 33'(0));
        check("stray_sel", 33'(xr_sel_o), 33'(0));
        check("stray_busy", 33'(busy_o), 33'(0));
        check("stray_rd", 33'(rd_data_o), 33'(0));
        exp_q.push_back(mk(0, 16'h0001, 0));
        do_op(OP_DR, 16'h0000, 16'h0001);
        check("post_rst_rd", 33'(rd_data_o), 33'(rd_model(16'h0001)));
        check("final_q", 33'(exp_q.size()), 33'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
